sdp_ram_be: RTL and testbench
=============================

Name: sdp_ram_be

Overview:
- Parametrised simple dual-port RAM with one write port and one read port on a single clock.
- Successor to the single-port RAM primitive. Adds:
  - independent read and write addresses;
  - per-lane write enables;
  - read enable with valid tracking;
  - selectable read-during-write mode;
  - optional output register stage.
- Array coding stays block-RAM inferable. Used by FIFOs, line buffers and frame stores.

Parameters:
- SIZE, 8, word width in bits; must be a multiple of LANE, else elaboration error.
- DEPTH, 16, number of entries; need not be a power of two.
- LANE, 8, bits per write-enable lane; LANES = SIZE/LANE.
- RD_MODE, 0, read-during-write to same address: 0 = old data, 1 = new data (write-first, per lane).
- OUT_REG, 0, 1 adds an output pipeline register; read latency = 1 + OUT_REG.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  $clog2(DEPTH)  write address.
- wr_data  in  SIZE  write data.
- wr_mask  in  LANES  lane enables; bit i covers wr_data[i*LANE +: LANE].
- rd_en  in  1  read strobe.
- rd_addr  in  $clog2(DEPTH)  read address.
- rd_data  out  SIZE  read data.
- rd_valid  out  1  rd_data carries the result of a read issued 1+OUT_REG cycles earlier.

Behaviour:
- Reset:
  - rd_valid = 0; rd_data = 0; all pipeline valid/data registers cleared.
  - Memory contents are NOT cleared; power-up contents are undefined.
  - Reset has priority over wr_en and rd_en in the same cycle: no write occurs and no read is issued.
- Write:
  - On the clk edge with rst_n=1 and wr_en=1, each lane i with wr_mask[i]=1 is updated; other lanes keep their value.
  - wr_mask all zero is a no-op.
  - wr_addr >= DEPTH is ignored; memory is unchanged.
- Read stage 1:
  - On the edge with rd_en=1, the array word at rd_addr is captured and v1 <= 1.
  - With rd_en=0: v1 <= 0 and the stage-1 data register holds its value.
  - rd_addr >= DEPTH returns unspecified data, but valid still asserts.
- OUT_REG=0: rd_data/rd_valid are the stage-1 registers; latency 1.
- OUT_REG=1:
  - Second register stage: rd_valid <= v1; rd_data loads only when v1=1, else holds.
  - Latency 2. Full throughput: one read per cycle, back-to-back.
- rd_data holds its last value while rd_valid=0; never returns to 0 except on reset.
- Collision: rd_en & wr_en & rd_addr==wr_addr in the same cycle.
  - RD_MODE=0: returned word is the pre-write contents.
  - RD_MODE=1: returned word = wr_data on lanes with wr_mask=1, old contents on the remaining lanes.
  - Implement with a registered collision flag plus registered wr_data/wr_mask, and a per-lane mux after the array read. The array itself is always read-first.
- Read at A in cycle n+1 after a write to A in cycle n returns the new data in both modes.
- Reset mid-read: in-flight reads are discarded; rd_valid is 0 on the cycle after reset and stays 0 until a new read completes.
- Ports are fully independent; there is no back-pressure and no ready signal.

Decomposition:
- Package sdp_ram_pkg: constants RD_OLD=0, RD_NEW=1; function lanes(SIZE,LANE).
- Sub-module sdp_ram_core: the bare array with masked write and read-first registered read, no reset. Keeps block-RAM inference isolated.
- Top level owns: valid pipeline, collision bypass, OUT_REG stage, reset.

Test Plan:
- Reset and hold: rst_n=0 for 3 cycles with rd_en=1 and wr_en=1 -> rd_valid=0 and rd_data=0 throughout. After release, a read of the address written during reset returns its prior contents, not the write data.
- Masked write (SIZE=32, LANE=8): write 0xAABBCCDD to addr 3 with mask 1111, then 0x11223344 with mask 0101 -> read addr 3 returns 0xAA22CC44 after 1+OUT_REG cycles with rd_valid=1.
- Collision, RD_MODE=0 vs 1: addr 5 holds 0x00000000; same-cycle write 0xFFFFFFFF mask 0011 and read addr 5 -> RD_MODE=0 returns 0x00000000; RD_MODE=1 returns 0x0000FFFF. Next-cycle read returns 0x0000FFFF in both modes.
- Streaming, OUT_REG=1: rd_en held high for 8 cycles over addrs 0..7 preloaded with 0x10..0x17 -> rd_valid high for exactly 8 consecutive cycles starting 2 cycles after the first rd_en, with data 0x10..0x17 in order. After the burst, rd_data holds 0x17.
- Non-power-of-two DEPTH=10: write to addr 12 -> no entry 0..9 changes, verified by full readback. Write to addr 9 then read -> value correct.
- Reset mid-read, OUT_REG=1: issue a read, assert rst_n=0 on the next edge -> rd_valid never asserts for that read.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// ============================================================================
// Module  : sdp_ram_pkg
// Brief   : Shared constants and helpers for the byte-enable dual-port RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sdp_ram_pkg;

    // Read-during-write behaviour on a same-address collision
    localparam int RD_OLD = 0;
    localparam int RD_NEW = 1;

    function automatic int lanes(input int size, input int lane);
        return size / lane;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_ram_core.sv
// ============================================================================
// Module  : sdp_ram_core
// Brief   : Bare storage array with lane-masked write and read-first
//           registered read; no reset so block RAM inference is preserved.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdp_ram_core #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16,
    parameter int LANE  = 8,
    parameter int LANES = 1,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SIZE-1:0]  wr_data,
    input  logic [LANES-1:0] wr_mask,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [SIZE-1:0]  rd_data
);

    localparam logic [AW:0] c_DEPTH = DEPTH[AW:0];

    logic [SIZE-1:0] r_mem [DEPTH];
    logic [SIZE-1:0] r_rd_data;
    logic            w_wr_in_range;

    // Addresses past the last entry exist when DEPTH is not a power of two
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    r_mem[wr_addr][i*LANE +: LANE] <= wr_data[i*LANE +: LANE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sdp_ram_be.sv
// ============================================================================
// Module  : sdp_ram_be
// Brief   : Simple dual-port RAM with per-lane write enables, read valid
//           tracking, selectable read-during-write and optional output stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdp_ram_be
    import sdp_ram_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int DEPTH   = 16,
    parameter int LANE    = 8,
    parameter int RD_MODE = RD_OLD,
    parameter int OUT_REG = 0,
    localparam int LANES  = lanes(SIZE, LANE),
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SIZE-1:0]  wr_data,
    input  logic [LANES-1:0] wr_mask,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [SIZE-1:0]  rd_data,
    output logic             rd_valid
);

    generate
        if ((SIZE % LANE) != 0 || SIZE < LANE) begin : g_bad_lane
            $error("sdp_ram_be: SIZE must be a non-zero multiple of LANE");
        end
    endgenerate

    logic            w_wr_go;
    logic            w_rd_go;
    logic [SIZE-1:0] w_arr_data;
    logic [SIZE-1:0] w_byp_data;
    logic [SIZE-1:0] w_s1_data;
    logic            r_v1;
    logic            r_empty;

    // Reset wins over both strobes: nothing reaches the array while held
    assign w_wr_go = wr_en & rst_n;
    assign w_rd_go = rd_en & rst_n;

    sdp_ram_core #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .LANE  (LANE),
        .LANES (LANES),
        .AW    (AW)
    ) u_core (
        .clk     (clk),
        .wr_en   (w_wr_go),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_mask (wr_mask),
        .rd_en   (w_rd_go),
        .rd_addr (rd_addr),
        .rd_data (w_arr_data)
    );

    // r_empty masks the unreset array register to zero until the first read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_v1 <= rd_en;
            if (rd_en) begin
                r_empty <= 1'b0;
            end
        end
    end

    generate
        if (RD_MODE == RD_NEW) begin : g_write_first
            logic             r_coll;
            logic [SIZE-1:0]  r_wdata;
            logic [LANES-1:0] r_wmask;

            // Bypass state only advances with a read so held data stays stable
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_coll <= 1'b0;
                end else if (rd_en) begin
                    r_coll <= wr_en && (wr_addr == rd_addr);
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n && rd_en) begin
                    r_wdata <= wr_data;
                    r_wmask <= wr_mask;
                end
            end

            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign w_byp_data[i*LANE +: LANE] = (r_coll && r_wmask[i])
                                                  ? r_wdata[i*LANE +: LANE]
                                                  : w_arr_data[i*LANE +: LANE];
            end
        end else begin : g_read_first
            assign w_byp_data = w_arr_data;
        end
    endgenerate

    assign w_s1_data = r_empty ? '0 : w_byp_data;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic            r_v2;
            logic [SIZE-1:0] r_d2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= w_s1_data;
                    end
                end
            end

            assign rd_valid = r_v2;
            assign rd_data  = r_d2;
        end else begin : g_no_out_reg
            assign rd_valid = r_v1;
            assign rd_data  = w_s1_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_be.sv
// ============================================================================
// Module  : tb_sdp_ram_be
// Brief   : Directed bench driving four RAM configurations from one stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sdp_ram_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        rd_en;
    logic [3:0]  rd_addr;

    // a: old/lat1, b: new/lat2, c: new/lat1/depth10, d: old/lat2
    logic [31:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
    logic        rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_ram_be #(.SIZE(32), .DEPTH(16), .LANE(8), .RD_MODE(0), .OUT_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));
    sdp_ram_be #(.SIZE(32), .DEPTH(16), .LANE(8), .RD_MODE(1), .OUT_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));
    sdp_ram_be #(.SIZE(32), .DEPTH(10), .LANE(8), .RD_MODE(1), .OUT_REG(0)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c));
    sdp_ram_be #(.SIZE(32), .DEPTH(16), .LANE(8), .RD_MODE(0), .OUT_REG(1)) u_d (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_d), .rd_valid(rd_valid_d));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_mask = mask;
        step;
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        do_write(4'd2, 32'h12345678, 4'hF);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 32'hDEADBEEF;
        wr_mask = 4'hF;
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        for (int c = 0; c < 3; c++) begin
            step;
            checks++;
            if ({rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_valid cycle %0d: got %b expected 0000", c,
                         {rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d});
            end
            checks++;
            if ({rd_data_a, rd_data_b, rd_data_c, rd_data_d} !== 128'h0) begin
                errors++;
                $display("FAIL reset_data cycle %0d: got %h expected 0", c,
                         {rd_data_a, rd_data_b, rd_data_c, rd_data_d});
            end
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        step;
        checks++;
        if ({rd_valid_a, rd_valid_c, rd_data_a, rd_data_c} !== {2'b11, 32'h12345678, 32'h12345678}) begin
            errors++;
            $display("FAIL post_reset_lat1: got %b %b %h %h expected 1 1 12345678 12345678",
                     rd_valid_a, rd_valid_c, rd_data_a, rd_data_c);
        end
        checks++;
        if ({rd_valid_b, rd_valid_d, rd_data_b, rd_data_d} !== {2'b00, 64'h0}) begin
            errors++;
            $display("FAIL post_reset_lat2_early: got %b %b %h %h expected 0 0 0 0",
                     rd_valid_b, rd_valid_d, rd_data_b, rd_data_d);
        end
        rd_en = 1'b0;
        step;
        checks++;
        if ({rd_valid_b, rd_valid_d, rd_data_b, rd_data_d} !== {2'b11, 32'h12345678, 32'h12345678}) begin
            errors++;
            $display("FAIL post_reset_lat2: got %b %b %h %h expected 1 1 12345678 12345678",
                     rd_valid_b, rd_valid_d, rd_data_b, rd_data_d);
        end
        checks++;
        if ({rd_valid_a, rd_valid_c, rd_data_a, rd_data_c} !== {2'b00, 32'h12345678, 32'h12345678}) begin
            errors++;
            $display("FAIL post_reset_hold: got %b %b %h %h expected 0 0 12345678 12345678",
                     rd_valid_a, rd_valid_c, rd_data_a, rd_data_c);
        end
    endtask

    task automatic test_masked_write;
        do_write(4'd3, 32'hAABBCCDD, 4'b1111);
        do_write(4'd3, 32'h11223344, 4'b0101);
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        step;
        rd_en = 1'b0;
        checks++;
        if ({rd_valid_a, rd_valid_c, rd_data_a, rd_data_c} !== {2'b11, 32'hAA22CC44, 32'hAA22CC44}) begin
            errors++;
            $display("FAIL masked_lat1: got %b %b %h %h expected 1 1 aa22cc44 aa22cc44",
                     rd_valid_a, rd_valid_c, rd_data_a, rd_data_c);
        end
        step;
        checks++;
        if ({rd_valid_b, rd_valid_d, rd_data_b, rd_data_d} !== {2'b11, 32'hAA22CC44, 32'hAA22CC44}) begin
            errors++;
            $display("FAIL masked_lat2: got %b %b %h %h expected 1 1 aa22cc44 aa22cc44",
                     rd_valid_b, rd_valid_d, rd_data_b, rd_data_d);
        end
    endtask

    task automatic test_collision;
        do_write(4'd5, 32'h00000000, 4'hF);
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'hFFFFFFFF;
        wr_mask = 4'b0011;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step;
        wr_en = 1'b0;
        checks++;
        if ({rd_valid_a, rd_data_a, rd_valid_c, rd_data_c} !== {1'b1, 32'h00000000, 1'b1, 32'h0000FFFF}) begin
            errors++;
            $display("FAIL collision_lat1: got old=%h new=%h expected old=00000000 new=0000ffff",
                     rd_data_a, rd_data_c);
        end
        step;
        rd_en = 1'b0;
        checks++;
        if ({rd_valid_b, rd_data_b, rd_valid_d, rd_data_d} !== {1'b1, 32'h0000FFFF, 1'b1, 32'h00000000}) begin
            errors++;
            $display("FAIL collision_lat2: got new=%h old=%h expected new=0000ffff old=00000000",
                     rd_data_b, rd_data_d);
        end
        checks++;
        if ({rd_valid_a, rd_data_a, rd_valid_c, rd_data_c} !== {1'b1, 32'h0000FFFF, 1'b1, 32'h0000FFFF}) begin
            errors++;
            $display("FAIL after_write_lat1: got %h %h expected 0000ffff 0000ffff", rd_data_a, rd_data_c);
        end
        step;
        checks++;
        if ({rd_valid_b, rd_data_b, rd_valid_d, rd_data_d} !== {1'b1, 32'h0000FFFF, 1'b1, 32'h0000FFFF}) begin
            errors++;
            $display("FAIL after_write_lat2: got %h %h expected 0000ffff 0000ffff", rd_data_b, rd_data_d);
        end
        // Second collision, then an idle cycle: write-first result must hold
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'h12345678;
        wr_mask = 4'b1000;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if ({rd_data_a, rd_data_c} !== {32'h0000FFFF, 32'h1200FFFF}) begin
            errors++;
            $display("FAIL collision2_lat1: got old=%h new=%h expected old=0000ffff new=1200ffff",
                     rd_data_a, rd_data_c);
        end
        step;
        checks++;
        if ({rd_valid_c, rd_data_c, rd_valid_a, rd_data_a} !== {1'b0, 32'h1200FFFF, 1'b0, 32'h0000FFFF}) begin
            errors++;
            $display("FAIL collision_hold: got %b %h %b %h expected 0 1200ffff 0 0000ffff",
                     rd_valid_c, rd_data_c, rd_valid_a, rd_data_a);
        end
        checks++;
        if ({rd_valid_b, rd_data_b, rd_valid_d, rd_data_d} !== {1'b1, 32'h1200FFFF, 1'b1, 32'h0000FFFF}) begin
            errors++;
            $display("FAIL collision2_lat2: got new=%h old=%h expected new=1200ffff old=0000ffff",
                     rd_data_b, rd_data_d);
        end
    endtask

    task automatic test_streaming;
        for (int i = 0; i < 8; i++) begin
            do_write(i[3:0], 32'h10 + 32'(i), 4'hF);
        end
        step;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            exp     = 32'h10 + 32'(i);
            rd_en   = 1'b1;
            rd_addr = i[3:0];
            step;
            checks++;
            if ({rd_valid_a, rd_data_a} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL stream_lat1 beat %0d: got %b %h expected 1 %h", i, rd_valid_a, rd_data_a, exp);
            end
            checks++;
            if (i == 0) begin
                if ({rd_valid_b, rd_valid_d} !== 2'b00) begin
                    errors++;
                    $display("FAIL stream_lat2_start: got %b %b expected 0 0", rd_valid_b, rd_valid_d);
                end
            end else if ({rd_valid_b, rd_valid_d, rd_data_b, rd_data_d} !== {2'b11, exp - 32'd1, exp - 32'd1}) begin
                errors++;
                $display("FAIL stream_lat2 beat %0d: got %b %b %h %h expected 1 1 %h", i - 1,
                         rd_valid_b, rd_valid_d, rd_data_b, rd_data_d, exp - 32'd1);
            end
        end
        rd_en = 1'b0;
        step;
        checks++;
        if ({rd_valid_b, rd_valid_d, rd_data_b, rd_data_d, rd_valid_a} !== {2'b11, 32'h17, 32'h17, 1'b0}) begin
            errors++;
            $display("FAIL stream_last: got %b %b %h %h a_valid=%b expected 1 1 17 17 a_valid=0",
                     rd_valid_b, rd_valid_d, rd_data_b, rd_data_d, rd_valid_a);
        end
        step;
        checks++;
        if ({rd_valid_b, rd_valid_d, rd_data_b, rd_data_d} !== {2'b00, 32'h17, 32'h17}) begin
            errors++;
            $display("FAIL stream_end_hold: got %b %b %h %h expected 0 0 17 17",
                     rd_valid_b, rd_valid_d, rd_data_b, rd_data_d);
        end
    endtask

    task automatic test_depth10;
        do_write(4'd8, 32'h00000088, 4'hF);
        do_write(4'd9, 32'h00000099, 4'hF);
        do_write(4'd12, 32'hBADBAD00, 4'hF);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] exp;
            if (i < 8)       exp = 32'h10 + 32'(i);
            else if (i == 8) exp = 32'h88;
            else             exp = 32'h99;
            rd_en   = 1'b1;
            rd_addr = i[3:0];
            step;
            checks++;
            if ({rd_valid_c, rd_data_c} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL depth10_readback addr %0d: got %b %h expected 1 %h", i, rd_valid_c, rd_data_c, exp);
            end
        end
        rd_addr = 4'd12;
        step;
        rd_en = 1'b0;
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 32'hBADBAD00}) begin
            errors++;
            $display("FAIL depth16_addr12: got %b %h expected 1 badbad00", rd_valid_a, rd_data_a);
        end
        do_write(4'd9, 32'hCAFEF00D, 4'hF);
        rd_en   = 1'b1;
        rd_addr = 4'd9;
        step;
        rd_en = 1'b0;
        checks++;
        if ({rd_valid_c, rd_data_c} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL depth10_last_entry: got %b %h expected 1 cafef00d", rd_valid_c, rd_data_c);
        end
        step;
    endtask

    task automatic test_reset_midread;
        rd_en   = 1'b1;
        rd_addr = 4'd1;
        step;
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL midread_issue: got %b %h expected 1 00000011", rd_valid_a, rd_data_a);
        end
        rst_n = 1'b0;
        rd_en = 1'b0;
        step;
        checks++;
        if ({rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d} !== 4'b0000) begin
            errors++;
            $display("FAIL midread_discard: got %b expected 0000",
                     {rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step;
            checks++;
            if ({rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d, rd_data_a, rd_data_b, rd_data_c, rd_data_d}
                    !== {4'b0000, 128'h0}) begin
                errors++;
                $display("FAIL midread_after cycle %0d: got %b %h expected 0000 0", c,
                         {rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d},
                         {rd_data_a, rd_data_b, rd_data_c, rd_data_d});
            end
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        #1;
        test_reset;
        test_masked_write;
        test_collision;
        test_streaming;
        test_depth10;
        test_reset_midread;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
